flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/nmi_edge_det.sv | 52 +++++
 rtl/flag_unit.sv | 163 ++++++++++++++++
 tb/tb_flag_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the status-flag logic.
//   - set_op_e  : encodings of the explicit flag set/clear operations
//   - P_*       : bit positions of each flag inside the processor status byte
//   - M_*       : bit positions inside the {N,V,Z,C} ALU update mask
//   - pack_p()  : assembles a status byte in stack-push layout
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    SOP_NOP = 3'd0,
    SOP_CLC = 3'd1,
    SOP_SEC = 3'd2,
    SOP_CLI = 3'd3,
    SOP_SEI = 3'd4,
    SOP_CLV = 3'd5,
    SOP_CLD = 3'd6,
    SOP_SED = 3'd7
  } set_op_e;

  // Status byte layout {N,V,1,B,D,I,Z,C}
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // ALU update mask layout {N,V,Z,C}
  localparam int M_C = 0;
  localparam int M_Z = 1;
  localparam int M_V = 2;
  localparam int M_N = 3;

  function automatic logic [7:0] pack_p(input logic n, input logic v,
                                        input logic b, input logic d,
                                        input logic i, input logic z,
                                        input logic c);
    logic [7:0] p;
    p      = 8'h00;
    p[P_N] = n;
    p[P_V] = v;
    p[P_U] = 1'b1;   // unused bit always reads as 1 when pushed
    p[P_B] = b;
    p[P_D] = d;
    p[P_I] = i;
    p[P_Z] = z;
    p[P_C] = c;
    return p;
  endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// -----------------------------------------------------------------------------
// nmi_edge_det
// Falling-edge detector and pending latch for the active-low NMI line.
// Ports:
//   clk      in   CPU clock
//   reset    in   asynchronous active-high reset
//   ce       in   cycle enable; state only moves on ce=1 edges
//   nmi_n    in   raw active-low NMI line
//   nmi_ack  in   NMI sequence started; clears the pending flag
//   nmi_pend out  an NMI edge has been seen and not yet acknowledged
// -----------------------------------------------------------------------------
module nmi_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic nmi_n,
  input  logic nmi_ack,
  output logic nmi_pend
);

  logic nmi_n_q;
  logic pend_q;
  logic pend_d;
  logic fall;

  // A fall is the previously sampled level high and the current level low.
  assign fall = nmi_n_q & ~nmi_n;

  // A new edge arriving in the same cycle as the acknowledge must not be lost,
  // so the edge takes priority over the clear.
  always_comb begin
    pend_d = pend_q;
    if (fall) begin
      pend_d = 1'b1;
    end else if (nmi_ack) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_n_q <= 1'b1;
      pend_q  <= 1'b0;
    end else if (ce) begin
      nmi_n_q <= nmi_n;
      pend_q  <= pend_d;
    end
  end

  assign nmi_pend = pend_q;

endmodule

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
// Processor status flags (C,Z,I,D,V,N) plus interrupt request generation.
// Optional feature macro: FLAG_UNIT_DECIMAL_EN -- when defined the D flag is
// stored and updated by CLD/SED/pull; otherwise D is constant 0.
// Ports:
//   clk, reset        in   CPU clock, asynchronous active-high reset
//   ce                in   cycle enable
//   alu_co/vo/so/zo   in   carry/overflow/sign/zero from the ALU
//   upd_mask[3:0]     in   {N,V,Z,C} load enables from the ALU flags
//   set_op[2:0]       in   explicit set/clear operation (cpu_pkg::set_op_e)
//   pull, pull_data   in   load P from a popped stack byte (PLP/RTI)
//   push_brk          in   B bit value for the pushed status byte
//   instr_end         in   last cycle of the current instruction
//   irq_n, nmi_n      in   active-low interrupt lines
//   nmi_ack           in   NMI sequence started
//   ci_out, vi_out    out  current C and V for the ALU
//   p_push[7:0]       out  status byte {N,V,1,B,D,I,Z,C} for pushing
//   int_req           out  interrupt pending at the next instruction boundary
//   int_is_nmi        out  the pending interrupt is an NMI
// -----------------------------------------------------------------------------
module flag_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       alu_co,
  input  logic       alu_vo,
  input  logic       alu_so,
  input  logic       alu_zo,
  input  logic [3:0] upd_mask,
  input  logic [2:0] set_op,
  input  logic       pull,
  input  logic [7:0] pull_data,
  input  logic       push_brk,
  input  logic       instr_end,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       nmi_ack,
  output logic       ci_out,
  output logic       vi_out,
  output logic [7:0] p_push,
  output logic       int_req,
  output logic       int_is_nmi
);

  logic c_q, z_q, i_q, v_q, n_q;
  logic c_d, z_d, i_d, v_d, n_d;
  logic d_flag;
  logic i_eff_q;
  logic irq_n_q;
  logic nmi_pend;
  set_op_e op;

  assign op = set_op_e'(set_op);

  // Next-state flags: a pull overrides everything; otherwise ALU loads are
  // applied first and the explicit set/clear op is layered on top so it wins.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    v_d = v_q;
    n_d = n_q;
    if (pull) begin
      c_d = pull_data[P_C];
      z_d = pull_data[P_Z];
      i_d = pull_data[P_I];
      v_d = pull_data[P_V];
      n_d = pull_data[P_N];
    end else begin
      if (upd_mask[M_C]) c_d = alu_co;
      if (upd_mask[M_Z]) z_d = alu_zo;
      if (upd_mask[M_V]) v_d = alu_vo;
      if (upd_mask[M_N]) n_d = alu_so;
      case (op)
        SOP_CLC: c_d = 1'b0;
        SOP_SEC: c_d = 1'b1;
        SOP_CLI: i_d = 1'b0;
        SOP_SEI: i_d = 1'b1;
        SOP_CLV: v_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      i_q     <= 1'b1;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      i_eff_q <= 1'b1;
      irq_n_q <= 1'b1;
    end else if (ce) begin
      c_q     <= c_d;
      z_q     <= z_d;
      i_q     <= i_d;
      v_q     <= v_d;
      n_q     <= n_d;
      irq_n_q <= irq_n;
      // The mask used for IRQ gating follows I only at instruction
      // boundaries, so a change to I takes effect one instruction later.
      if (instr_end) begin
        i_eff_q <= i_q;
      end
    end
  end

`ifdef FLAG_UNIT_DECIMAL_EN
  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d_q;
    if (pull) begin
      d_d = pull_data[P_D];
    end else if (op == SOP_CLD) begin
      d_d = 1'b0;
    end else if (op == SOP_SED) begin
      d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
    end else if (ce) begin
      d_q <= d_d;
    end
  end

  assign d_flag = d_q;

  // Bits 5 and 4 of a pulled byte have no storage.
  logic unused_pull_bits;
  assign unused_pull_bits = ^pull_data[P_U:P_B];
`else
  assign d_flag = 1'b0;

  // Bits 5, 4 and (without decimal mode) 3 of a pulled byte have no storage.
  logic unused_pull_bits;
  assign unused_pull_bits = ^pull_data[P_U:P_D];
`endif

  nmi_edge_det u_nmi_edge_det (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .nmi_n    (nmi_n),
    .nmi_ack  (nmi_ack),
    .nmi_pend (nmi_pend)
  );

  assign ci_out     = c_q;
  assign vi_out     = v_q;
  assign p_push     = pack_p(n_q, v_q, push_brk, d_flag, i_q, z_q, c_q);
  assign int_req    = nmi_pend | (~irq_n_q & ~i_eff_q);
  assign int_is_nmi = nmi_pend;

endmodule

// File: tb/tb_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_unit
// Directed test for flag_unit. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_flag_unit;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       alu_co, alu_vo, alu_so, alu_zo;
  logic [3:0] upd_mask;
  logic [2:0] set_op;
  logic       pull;
  logic [7:0] pull_data;
  logic       push_brk;
  logic       instr_end;
  logic       irq_n, nmi_n, nmi_ack;
  logic       ci_out, vi_out;
  logic [7:0] p_push;
  logic       int_req, int_is_nmi;

  int n_cmp = 0;
  int n_err = 0;

  // D flag expected after a pull / SED with the decimal feature
`ifdef FLAG_UNIT_DECIMAL_EN
  localparam logic [7:0] D_BIT = 8'h08;
`else
  localparam logic [7:0] D_BIT = 8'h00;
`endif

  flag_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .alu_co     (alu_co),
    .alu_vo     (alu_vo),
    .alu_so     (alu_so),
    .alu_zo     (alu_zo),
    .upd_mask   (upd_mask),
    .set_op     (set_op),
    .pull       (pull),
    .pull_data  (pull_data),
    .push_brk   (push_brk),
    .instr_end  (instr_end),
    .irq_n      (irq_n),
    .nmi_n      (nmi_n),
    .nmi_ack    (nmi_ack),
    .ci_out     (ci_out),
    .vi_out     (vi_out),
    .p_push     (p_push),
    .int_req    (int_req),
    .int_is_nmi (int_is_nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
    $display("check %-14s observed %02h expected %02h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1;
    alu_co = 1'b0; alu_vo = 1'b0; alu_so = 1'b0; alu_zo = 1'b0;
    upd_mask = 4'h0; set_op = 3'd0; pull = 1'b0; pull_data = 8'h00;
    push_brk = 1'b0; instr_end = 1'b0; irq_n = 1'b1; nmi_n = 1'b1; nmi_ack = 1'b0;

    // ---- reset state
    tick(); tick();
    chk("rst_ci",     {7'd0, ci_out}, 8'h00);
    chk("rst_vi",     {7'd0, vi_out}, 8'h00);
    chk("rst_intreq", {7'd0, int_req}, 8'h00);
    chk("rst_p",      p_push, 8'h24);
    push_brk = 1'b1; #1;
    chk("rst_p_brk",  p_push, 8'h34);
    push_brk = 1'b0;
    reset = 1'b0;
    tick();

    // ---- SEC, then ALU load of C=0, then C=1, then N/Z load
    set_op = 3'd2; tick();
    chk("sec_ci",     {7'd0, ci_out}, 8'h01);
    chk("sec_p",      p_push, 8'h25);
    set_op = 3'd0; upd_mask = 4'b0001; alu_co = 1'b0; tick();
    chk("aluc0_ci",   {7'd0, ci_out}, 8'h00);
    alu_co = 1'b1; tick();
    chk("aluc1_ci",   {7'd0, ci_out}, 8'h01);
    upd_mask = 4'b1010; alu_so = 1'b1; alu_zo = 1'b1; alu_co = 1'b0; tick();
    chk("alu_nz_p",   p_push, 8'hA7);

    // ---- pull overrides mask and set_op
    upd_mask = 4'hF; alu_so = 1'b0; alu_zo = 1'b0; alu_vo = 1'b0;
    set_op = 3'd1; pull = 1'b1; pull_data = 8'hC3; tick();
    chk("pull_c3_p",  p_push, 8'hE3);
    chk("pull_c3_ci", {7'd0, ci_out}, 8'h01);
    chk("pull_c3_vi", {7'd0, vi_out}, 8'h01);
    set_op = 3'd0; upd_mask = 4'h0;
    pull_data = 8'h3C; tick();
    chk("pull_3c_p",  p_push, 8'h24 | D_BIT);
    pull = 1'b0; pull_data = 8'h00;
    set_op = 3'd6; tick();
    chk("cld_p",      p_push, 8'h24);
    set_op = 3'd7; tick();
    chk("sed_p",      p_push, 8'h24 | D_BIT);
    set_op = 3'd6; tick();
    set_op = 3'd0;

    // ---- CLV wins over ALU V load; ce=0 holds state
    upd_mask = 4'b0100; alu_vo = 1'b1; tick();
    chk("aluv_vi",    {7'd0, vi_out}, 8'h01);
    set_op = 3'd5; tick();
    chk("clv_vi",     {7'd0, vi_out}, 8'h00);
    upd_mask = 4'h0; alu_vo = 1'b0;
    ce = 1'b0; set_op = 3'd2; tick();
    chk("ce0_sec_ci", {7'd0, ci_out}, 8'h00);
    ce = 1'b1; set_op = 3'd0;

    // ---- CLI latency through instr_end
    irq_n = 1'b0; tick();
    chk("irq_masked", {7'd0, int_req}, 8'h00);
    set_op = 3'd3; tick();
    set_op = 3'd0;
    chk("cli_p",      p_push, 8'h20);
    chk("cli_noreq",  {7'd0, int_req}, 8'h00);
    tick();
    chk("cli_wait",   {7'd0, int_req}, 8'h00);
    instr_end = 1'b1; #1;
    chk("iend_cycle", {7'd0, int_req}, 8'h00);
    tick();
    instr_end = 1'b0;
    chk("after_iend", {7'd0, int_req}, 8'h01);
    chk("irq_notnmi", {7'd0, int_is_nmi}, 8'h00);
    set_op = 3'd4; tick();
    set_op = 3'd0;
    chk("sei_latency",{7'd0, int_req}, 8'h01);
    instr_end = 1'b1; tick();
    instr_end = 1'b0;
    chk("sei_masked", {7'd0, int_req}, 8'h00);
    irq_n = 1'b1; tick();

    // ---- NMI edge detection
    nmi_n = 1'b0; tick();
    chk("nmi_set",    {7'd0, int_is_nmi}, 8'h01);
    chk("nmi_req",    {7'd0, int_req}, 8'h01);
    nmi_ack = 1'b1; tick();
    nmi_ack = 1'b0;
    chk("nmi_ack_clr",{7'd0, int_is_nmi}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("nmi_low_hold", {7'd0, int_is_nmi}, 8'h00);
    end
    nmi_n = 1'b1; tick();
    chk("nmi_rise",   {7'd0, int_is_nmi}, 8'h00);
    nmi_n = 1'b0; tick();
    chk("nmi_refall", {7'd0, int_is_nmi}, 8'h01);
    nmi_n = 1'b1; tick();
    nmi_n = 1'b0; nmi_ack = 1'b1; tick();
    nmi_ack = 1'b0;
    chk("edge_vs_ack",{7'd0, int_is_nmi}, 8'h01);
    ce = 1'b0; nmi_ack = 1'b1; tick();
    nmi_ack = 1'b0; ce = 1'b1;
    chk("ce0_ack",    {7'd0, int_is_nmi}, 8'h01);

    // ---- asynchronous reset mid-stream, with ce low
    set_op = 3'd3; tick();
    set_op = 3'd2; tick();
    set_op = 3'd0;
    chk("pre_rst_ci", {7'd0, ci_out}, 8'h01);
    ce = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_nmi",   {7'd0, int_is_nmi}, 8'h00);
    chk("arst_ci",    {7'd0, ci_out}, 8'h00);
    chk("arst_p",     p_push, 8'h24);
    chk("arst_req",   {7'd0, int_req}, 8'h00);
    tick();
    reset = 1'b0; ce = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
